// File: rtl/stopwatch_cu_pkg.sv
// stopwatch_cu_pkg: shared FSM encodings and default command/ack bytes for the stopwatch control path.
package stopwatch_cu_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_e;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    localparam logic [7:0] DEF_CMD_RUNSTOP = 8'h52;
    localparam logic [7:0] DEF_CMD_CLEAR   = 8'h43;
    localparam logic [7:0] DEF_CMD_MODE    = 8'h4D;
    localparam logic [7:0] DEF_ACK_STOP    = 8'h53;

endpackage

// File: rtl/sw_ack_tx.sv
// sw_ack_tx: one-entry ack pending register plus the handshake FSM that feeds the UART transmitter.
module sw_ack_tx
    import stopwatch_cu_pkg::*;
#(
    parameter bit ACK_EN    = 1'b1,
    parameter int BUSY_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ack_vld,
    input  logic [7:0] i_ack_byte,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data
);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    tx_state_e     tx_q, tx_d;
    logic          pend_q, pend_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic          start_q, start_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tx_d    = tx_q;
        pend_d  = pend_q;
        pbyte_d = pbyte_q;
        start_d = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (tx_q)
            TX_IDLE: if (pend_q && !i_tx_busy && ACK_EN) begin
                start_d = 1'b1;
                data_d  = pbyte_q;
                pend_d  = 1'b0;
                cnt_d   = '0;
                tx_d    = TX_WAIT_BUSY;
            end
            // a transmitter that never raises busy costs one byte, never a retry
            TX_WAIT_BUSY: if (i_tx_busy) tx_d = TX_WAIT_DONE;
                else if (cnt_q == CW'(BUSY_WAIT - 1)) tx_d = TX_IDLE;
                else cnt_d = cnt_q + CW'(1);
            TX_WAIT_DONE: tx_d = i_tx_busy ? TX_WAIT_DONE : TX_IDLE;
            default: tx_d = TX_IDLE;
        endcase
        // latest ack wins, even over one being handed off this cycle
        if (i_ack_vld) begin
            pend_d  = 1'b1;
            pbyte_d = i_ack_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q    <= TX_IDLE;
            pend_q  <= 1'b0;
            pbyte_q <= 8'h00;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            tx_q    <= tx_d;
            pend_q  <= pend_d;
            pbyte_q <= pbyte_d;
            start_q <= start_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;

endmodule

// File: rtl/stopwatch_cu.sv
// stopwatch_cu: merges button pulses and UART commands into run/clear/mode events and acks each accepted one.
module stopwatch_cu
    import stopwatch_cu_pkg::*;
#(
    parameter logic [7:0] CMD_RUNSTOP = DEF_CMD_RUNSTOP,
    parameter logic [7:0] CMD_CLEAR   = DEF_CMD_CLEAR,
    parameter logic [7:0] CMD_MODE    = DEF_CMD_MODE,
    parameter logic [7:0] ACK_STOP    = DEF_ACK_STOP,
    parameter bit         ACK_EN      = 1'b1,
    parameter int         BUSY_WAIT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    input  logic       i_btn_mode,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_tx_busy,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_mode,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data
);

    sw_state_e  state_q, state_d;
    logic       mode_q, mode_d;
    logic       ev_rs, ev_clr, ev_mode;
    logic       ack_vld;
    logic [7:0] ack_byte;

    always_comb begin
        ev_rs    = i_btn_runstop | (i_rx_done & (i_rx_data == CMD_RUNSTOP));
        ev_clr   = i_btn_clear   | (i_rx_done & (i_rx_data == CMD_CLEAR));
        ev_mode  = i_btn_mode    | (i_rx_done & (i_rx_data == CMD_MODE));
        state_d  = state_q;
        ack_vld  = 1'b0;
        ack_byte = CMD_MODE;
        unique case (state_q)
            ST_STOP: if (ev_clr) begin
                state_d  = ST_CLEAR;
                ack_vld  = 1'b1;
                ack_byte = CMD_CLEAR;
            end else if (ev_rs) begin
                state_d  = ST_RUN;
                ack_vld  = 1'b1;
                ack_byte = CMD_RUNSTOP;
            end
            ST_RUN: if (ev_rs) begin
                state_d  = ST_STOP;
                ack_vld  = 1'b1;
                ack_byte = ACK_STOP;
            end
            default: state_d = ST_STOP;
        endcase
        // a state-change ack already owns ack_byte, so a coincident mode ack is dropped
        ack_vld = ack_vld | ev_mode;
        mode_d  = mode_q ^ ev_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign o_run   = (state_q == ST_RUN);
    assign o_clear = (state_q == ST_CLEAR);
    assign o_mode  = mode_q;

    sw_ack_tx #(
        .ACK_EN    (ACK_EN),
        .BUSY_WAIT (BUSY_WAIT)
    ) u_ack_tx (
        .clk        (clk),
        .rst        (rst),
        .i_ack_vld  (ack_vld),
        .i_ack_byte (ack_byte),
        .i_tx_busy  (i_tx_busy),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
    );

endmodule

// File: tb/tb_stopwatch_cu.sv
// tb_stopwatch_cu: directed test-plan scenarios plus random traffic, checked cycle by cycle against a behavioural model.
module tb_stopwatch_cu;

    localparam int BUSY_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_rs = 1'b0, btn_clr = 1'b0, btn_md = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic       o_run, o_clear, o_mode, o_tx_start;
    logic [7:0] o_tx_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_start = 0;
    int gap = 0;

    // reference model: stopwatch mode plus a pending ack and a cycles-since-start age
    bit         m_run, m_clr, m_mode, m_pend, m_start;
    logic [7:0] m_pbyte, m_data;
    int         m_tx, m_age;

    always #5 clk = ~clk;

    stopwatch_cu dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_runstop (btn_rs),
        .i_btn_clear   (btn_clr),
        .i_btn_mode    (btn_md),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_tx_busy     (tx_busy),
        .o_run         (o_run),
        .o_clear       (o_clear),
        .o_mode        (o_mode),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_clr = 0; m_mode = 0; m_pend = 0; m_start = 0;
        m_pbyte = 8'h00; m_data = 8'h00; m_tx = 0; m_age = 0;
    endtask

    task automatic model_step(input bit rs, input bit cl, input bit md, input bit rd,
                              input logic [7:0] rb, input bit busy);
        bit         ers, ecl, emd, ack;
        logic [7:0] ab;
        ers = rs | (rd && rb == 8'h52);
        ecl = cl | (rd && rb == 8'h43);
        emd = md | (rd && rb == 8'h4D);
        ack = 0;
        ab  = 8'h4D;
        if (m_clr) m_clr = 0;
        else if (!m_run) begin
            if (ecl) begin m_clr = 1; ack = 1; ab = 8'h43; end
            else if (ers) begin m_run = 1; ack = 1; ab = 8'h52; end
        end else if (ers) begin
            m_run = 0; ack = 1; ab = 8'h53;
        end
        if (emd) begin m_mode = !m_mode; ack = 1; end
        m_start = 0;
        if (m_tx == 0) begin
            if (m_pend && !busy) begin
                m_start = 1; m_data = m_pbyte; m_pend = 0; m_tx = 1; m_age = 1;
            end
        end else if (m_tx == 1) begin
            if (busy) m_tx = 2;
            else if (m_age == BUSY_WAIT) m_tx = 0;
            else m_age++;
        end else if (!busy) m_tx = 0;
        if (ack) begin m_pend = 1; m_pbyte = ab; end
    endtask

    task automatic step(input bit rs, input bit cl, input bit md, input bit rd,
                        input logic [7:0] rb, input bit busy);
        @(negedge clk);
        cyc++;
        chk("run", {7'd0, o_run}, {7'd0, m_run});
        chk("clear", {7'd0, o_clear}, {7'd0, m_clr});
        chk("mode", {7'd0, o_mode}, {7'd0, m_mode});
        chk("tx_start", {7'd0, o_tx_start}, {7'd0, m_start});
        chk("tx_data", o_tx_data, m_data);
        if (o_tx_start) begin
            gap = cyc - last_start;
            last_start = cyc;
        end
        btn_rs = rs; btn_clr = cl; btn_md = md; rx_done = rd; rx_data = rb; tx_busy = busy;
        model_step(rs, cl, md, rd, rb, busy);
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, busy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1;
        btn_rs = 0; btn_clr = 0; btn_md = 0; rx_done = 0; rx_data = 8'h00; tx_busy = 0;
        #1;
        chk("rst_run", {7'd0, o_run}, 8'd0);
        chk("rst_clear", {7'd0, o_clear}, 8'd0);
        chk("rst_mode", {7'd0, o_mode}, 8'd0);
        chk("rst_tx_start", {7'd0, o_tx_start}, 8'd0);
        chk("rst_tx_data", o_tx_data, 8'h00);
        rst = 0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(2, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        idle(1, 0);
        chk("rs_starts_run", {7'd0, o_run}, 8'd1);
        step(0, 0, 1, 0, 8'h00, 0);
        chk("ack_run_byte", o_tx_data, 8'h52);
        idle(8, 0);
        chk("busy_timeout_gap", 8'(gap), 8'd5);
        step(1, 0, 0, 0, 8'h00, 0);
        idle(1, 0);
        chk("rs_stops", {7'd0, o_run}, 8'd0);
        idle(2, 0);
        chk("ack_stop_byte", o_tx_data, 8'h53);
        idle(6, 0);
        step(0, 0, 0, 1, 8'h43, 0);
        idle(1, 0);
        chk("uart_clear_pulse", {7'd0, o_clear}, 8'd1);
        idle(1, 0);
        chk("clear_one_cycle", {7'd0, o_clear}, 8'd0);
        chk("clear_back_stop", {7'd0, o_run}, 8'd0);
        chk("ack_clear_byte", o_tx_data, 8'h43);
        idle(8, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        idle(1, 0);
        step(0, 0, 0, 1, 8'h43, 0);
        idle(1, 0);
        chk("clr_in_run", {7'd0, o_clear}, 8'd0);
        chk("run_kept", {7'd0, o_run}, 8'd1);
        idle(8, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        idle(8, 0);
        step(1, 0, 0, 1, 8'h52, 0);
        idle(1, 0);
        chk("merged_rs", {7'd0, o_run}, 8'd1);
        idle(8, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        idle(8, 0);
        step(0, 0, 0, 1, 8'h41, 0);
        idle(1, 0);
        chk("junk_byte_run", {7'd0, o_run}, 8'd0);
        chk("junk_byte_clr", {7'd0, o_clear}, 8'd0);
        step(1, 1, 0, 0, 8'h00, 0);
        idle(1, 0);
        chk("clr_prio_clear", {7'd0, o_clear}, 8'd1);
        chk("clr_prio_run", {7'd0, o_run}, 8'd0);
        idle(1, 0);
        chk("clr_prio_after", {7'd0, o_run}, 8'd0);
        idle(8, 0);
        step(1, 0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 0, 8'h00, 1);
        idle(3, 1);
        idle(1, 0);
        idle(1, 1);
        chk("latest_ack_start", {7'd0, o_tx_start}, 8'd1);
        chk("latest_ack_byte", o_tx_data, 8'h4D);
        idle(2, 1);
        chk("data_stable", o_tx_data, 8'h4D);
        idle(3, 0);
        step(0, 0, 1, 0, 8'h00, 0);
        idle(1, 0);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit         rd;
            logic [7:0] rb;
            bit         b;
            rd = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0: rb = 8'h52;
                1: rb = 8'h43;
                2: rb = 8'h4D;
                3: rb = 8'h53;
                default: rb = 8'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? !tx_busy : tx_busy;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0, rd, rb, b);
            if ($urandom_range(0, 599) == 0) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
